simple_err_seq: RTL and testbench

- Frame sequencer for the error-control stage.
- Fetches expected values from the expected-data memory and streams them to the error block as FRAME_LEN-element frames, with a first-element flag on each frame.
- Uses credit-based flow control: the number of values fetched but not yet returned as error results never exceeds MAX_OUT, so the error block's internal expected buffer cannot overflow.
- Sits between the training-control FSM (start/done) and the error block's expected input port.

---
 rtl/simple_err_seq_pkg.sv | 34 +++
 rtl/simple_err_seq_if.sv | 23 ++
 rtl/simple_err_skid2.sv | 62 ++++++
 rtl/simple_err_seq.sv | 177 +++++++++++++++++
 tb/tb_simple_err_seq.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_err_seq_pkg.sv
// Shared types and sizing for the error-control sequencer and the error block.
package simple_err_seq_pkg;

  localparam int unsigned FRAME_LEN = 36;
  localparam int unsigned MAX_OUT   = 35;
  localparam int unsigned MEM_DEPTH = 144;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned RES_W     = 7;
  localparam int unsigned ELEM_W    = 6;
  localparam int unsigned FRAME_W   = 8;

  // Raw bit image of a float_24_8 value
  typedef logic [DATA_W-1:0] float_24_8;

  // One buffered element: first-of-frame tag plus value
  typedef struct packed {
    logic      fst;
    float_24_8 value;
  } exp_elem_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Read address step with wrap at the last memory entry
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/simple_err_seq_if.sv
// Memory-read and expected-stream signals between sequencer, memory and error block.
interface simple_err_seq_if;
  import simple_err_seq_pkg::*;

  logic              exp_mem_rd_vld;
  logic [ADDR_W-1:0] exp_mem_rd_address;
  logic [DATA_W-1:0] exp_mem_rd_data;
  float_24_8         expected;
  logic              expected_fst;
  logic              expected_vld;
  logic              expected_rdy;
  logic              result_vld;

  modport master (
    output exp_mem_rd_vld, exp_mem_rd_address, expected, expected_fst, expected_vld,
    input  exp_mem_rd_data, expected_rdy, result_vld
  );

  modport slave (
    input  exp_mem_rd_vld, exp_mem_rd_address, expected, expected_fst, expected_vld,
    output exp_mem_rd_data, expected_rdy, result_vld
  );
endinterface

// File: rtl/simple_err_skid2.sv
// Two-entry valid/ready FIFO; the head entry is the registered output.
module simple_err_skid2
  import simple_err_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_vld_i,
  input  exp_elem_t  wr_data_i,
  input  logic       rd_rdy_i,
  output logic       rd_vld_o,
  output exp_elem_t  rd_data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] occ_o
);

  exp_elem_t  head_q;
  exp_elem_t  tail_q;
  logic [1:0] occ_q;
  logic       push_c;
  logic       pop_c;

  assign pop_c  = rd_vld_o & rd_rdy_i;
  assign push_c = wr_vld_i & (~full_o | pop_c);

  // Entry storage and occupancy; head only changes on pop or on write into empty
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push_c, pop_c})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= wr_data_i;
          else               tail_q <= wr_data_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= wr_data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_vld_o  = (occ_q != 2'd0);
  assign rd_data_o = head_q;
  assign full_o    = (occ_q == 2'd2);
  assign empty_o   = (occ_q == 2'd0);
  assign occ_o     = occ_q;

endmodule

// File: rtl/simple_err_seq.sv
// Frame sequencer: fetches expected values and streams FRAME_LEN-element frames
// under credit flow control. Optional SIMPLE_ERR_SEQ_STATS_EN adds stall_cycles.
module simple_err_seq
  import simple_err_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_frames,
  output logic       busy,
  output logic       done,
  simple_err_seq_if.master bus
`ifdef SIMPLE_ERR_SEQ_STATS_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  seq_state_e         state_q;
  logic               busy_q;
  logic               done_q;
  logic [FRAME_W-1:0] nframes_q;
  logic [FRAME_W-1:0] frame_q;
  logic [ELEM_W-1:0]  elem_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [RES_W-1:0]   reserved_q;
  logic [RES_W-1:0]   reserved_d;
  logic               inflight_q;
  logic               fst_pipe_q;

  logic       start_acc_c;
  logic       fetch_c;
  logic       last_fetch_c;
  logic       ret_c;
  logic       pop_c;
  logic       room_c;
  logic [2:0] level_c;

  exp_elem_t  wr_data_c;
  exp_elem_t  rd_data_c;
  logic       skid_vld_c;
  logic       skid_full_c;
  logic       skid_empty_c;
  logic [1:0] skid_occ_c;

  assign start_acc_c = (state_q == ST_IDLE) & start;
  assign pop_c       = skid_vld_c & bus.expected_rdy;
  // Buffer level after this cycle's pop, counting the read still in flight;
  // taking the pop into account is what allows one fetch per cycle
  assign level_c     = 3'(skid_occ_c) + 3'(inflight_q) - 3'(pop_c);
  assign room_c      = (level_c < 3'd2) & ~(skid_full_c & ~pop_c);
  assign fetch_c     = (state_q == ST_RUN) & (reserved_q < RES_W'(MAX_OUT)) & room_c;
  assign last_fetch_c = fetch_c & (elem_q == ELEM_W'(FRAME_LEN - 1))
                      & (frame_q == nframes_q - 8'd1);
  assign ret_c       = bus.result_vld & (reserved_q != '0);

  // Credit count: fetched values not yet returned as results
  always_comb begin
    reserved_d = reserved_q;
    if (fetch_c && !ret_c)      reserved_d = reserved_q + RES_W'(1);
    else if (!fetch_c && ret_c) reserved_d = reserved_q - RES_W'(1);
  end

  // Run-control FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nframes_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_frames != 8'd0) begin
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
              nframes_q <= num_frames;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (last_fetch_c) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Finish in the cycle the last credit comes back
          if ((reserved_d == '0) && skid_empty_c && !inflight_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch counters, credit register and read-return tag pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      elem_q     <= '0;
      frame_q    <= '0;
      addr_q     <= '0;
      reserved_q <= '0;
      inflight_q <= 1'b0;
      fst_pipe_q <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      inflight_q <= fetch_c;
      fst_pipe_q <= (elem_q == ELEM_W'(0));
      if (start_acc_c) begin
        elem_q  <= '0;
        frame_q <= '0;
      end else if (fetch_c) begin
        addr_q <= next_addr(addr_q);
        if (elem_q == ELEM_W'(FRAME_LEN - 1)) begin
          elem_q  <= '0;
          frame_q <= frame_q + 8'd1;
        end else begin
          elem_q <= elem_q + ELEM_W'(1);
        end
      end
    end
  end

  assign wr_data_c.fst   = fst_pipe_q;
  assign wr_data_c.value = bus.exp_mem_rd_data;

  simple_err_skid2 u_skid (
    .clk       (clk),
    .reset     (reset),
    .wr_vld_i  (inflight_q),
    .wr_data_i (wr_data_c),
    .rd_rdy_i  (bus.expected_rdy),
    .rd_vld_o  (skid_vld_c),
    .rd_data_o (rd_data_c),
    .full_o    (skid_full_c),
    .empty_o   (skid_empty_c),
    .occ_o     (skid_occ_c)
  );

  assign bus.exp_mem_rd_vld     = fetch_c;
  assign bus.exp_mem_rd_address = addr_q;
  assign bus.expected           = rd_data_c.value;
  assign bus.expected_fst       = rd_data_c.fst;
  assign bus.expected_vld       = skid_vld_c;
  assign busy                   = busy_q;
  assign done                   = done_q;

`ifdef SIMPLE_ERR_SEQ_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of RUN cycles blocked purely by exhausted credits
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_acc_c) begin
      stall_q <= '0;
    end else if ((state_q == ST_RUN) && (reserved_q == RES_W'(MAX_OUT)) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_simple_err_seq.sv
// Directed bench for simple_err_seq with memory, credit-return and scoreboard models.
module tb_simple_err_seq;
  import simple_err_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_frames;
  logic       busy;
  logic       done;
`ifdef SIMPLE_ERR_SEQ_STATS_EN
  logic [15:0] stall_cycles;
`endif

  simple_err_seq_if bus();

  simple_err_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_frames (num_frames),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
`ifdef SIMPLE_ERR_SEQ_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Expected memory: data one cycle after the read strobe
  always @(posedge clk)
    bus.exp_mem_rd_data <= bus.exp_mem_rd_vld ? memval(bus.exp_mem_rd_address) : 32'hDEAD_BEEF;

  // Error-block credit model: one result per accepted element
  int         cyc = 0;
  int         acc_t [0:255];
  logic [7:0] head = 8'd0;
  logic [7:0] tail = 8'd0;
  logic       auto_ret;
  logic       man_pulse;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      head <= tail;
      bus.result_vld <= 1'b0;
    end else begin
      if (bus.expected_vld && bus.expected_rdy) begin
        acc_t[tail] <= cyc;
        tail <= tail + 8'd1;
      end
      if ((head != tail) && ((auto_ret && (cyc >= acc_t[head] + 2)) || man_pulse)) begin
        bus.result_vld <= 1'b1;
        head <= head + 8'd1;
      end else begin
        bus.result_vld <= 1'b0;
      end
    end
  end

  // Scoreboard and monitors, sampled on the falling edge
  logic [7:0] exp_addr = 8'd0;
  int         elem_m = 0;
  logic [7:0] sb_a [0:15];
  logic       sb_f [0:15];
  logic [3:0] wp = 4'd0;
  logic [3:0] rp = 4'd0;
  logic       hold = 1'b0;
  logic [31:0] hold_d;
  logic       hold_f;
  int nfetch = 0, nfst = 0, ndone = 0, nwrap = 0;
  int last_ret = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_addr = 8'd0;
      elem_m   = 0;
      rp       = wp;
      hold     = 1'b0;
    end else begin
      if (hold) begin
        check("stall_vld", 64'(bus.expected_vld), 64'd1);
        check("stall_data", 64'(bus.expected), 64'(hold_d));
        check("stall_fst", 64'(bus.expected_fst), 64'(hold_f));
      end
      if (bus.exp_mem_rd_vld) begin
        check("rd_addr", 64'(bus.exp_mem_rd_address), 64'(exp_addr));
        sb_a[wp] = exp_addr;
        sb_f[wp] = (elem_m == 0);
        wp = wp + 4'd1;
        if (exp_addr == 8'd143) nwrap++;
        exp_addr = (exp_addr == 8'd143) ? 8'd0 : exp_addr + 8'd1;
        elem_m = (elem_m == 35) ? 0 : elem_m + 1;
        nfetch++;
      end
      if (bus.expected_vld && bus.expected_rdy) begin
        check("sb_nonempty", 64'(rp != wp), 64'd1);
        check("out_data", 64'(bus.expected), 64'(memval(sb_a[rp])));
        check("out_fst", 64'(bus.expected_fst), 64'(sb_f[rp]));
        if (bus.expected_fst) nfst++;
        rp = rp + 4'd1;
      end
      hold   = bus.expected_vld & ~bus.expected_rdy;
      hold_d = bus.expected;
      hold_f = bus.expected_fst;
      if (bus.result_vld) last_ret = cyc;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] nf);
    num_frames = nf;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check(tag, 64'(done), 64'd1);
    tick();
  endtask

  int f0, s0, d0, w0, n;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_frames = 8'd0;
    bus.expected_rdy = 1'b1;
    auto_ret = 1'b1;
    man_pulse = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_vld", 64'(bus.exp_mem_rd_vld), 64'd0);
    check("rst_addr", 64'(bus.exp_mem_rd_address), 64'd0);
    check("rst_vld", 64'(bus.expected_vld), 64'd0);
    check("rst_data", 64'(bus.expected), 64'd0);
    check("rst_fst", 64'(bus.expected_fst), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // One frame, results returned shortly after each accept
    f0 = nfetch; s0 = nfst; d0 = ndone;
    pulse_start(8'd1);
    @(negedge clk);
    check("a_lat_rd_vld", 64'(bus.exp_mem_rd_vld), 64'd1);
    check("a_first_addr", 64'(bus.exp_mem_rd_address), 64'd0);
    check("a_busy", 64'(busy), 64'd1);
    check("a_lat_vld_t1", 64'(bus.expected_vld), 64'd0);
    @(negedge clk);
    check("a_lat_vld_t2", 64'(bus.expected_vld), 64'd0);
    @(negedge clk);
    check("a_lat_vld_t3", 64'(bus.expected_vld), 64'd1);
    wait_done("a_done", 400);
    check("a_done_after_ret", 64'(done_cyc - last_ret), 64'd1);
    repeat (3) tick();
    check("a_fetches", 64'(nfetch - f0), 64'd36);
    check("a_fst_count", 64'(nfst - s0), 64'd1);
    check("a_done_count", 64'(ndone - d0), 64'd1);
    check("a_busy_end", 64'(busy), 64'd0);

    // Zero frames: immediate done, no reads
    f0 = nfetch;
    pulse_start(8'd0);
    @(negedge clk);
    check("z_done", 64'(done), 64'd1);
    check("z_busy", 64'(busy), 64'd0);
    check("z_rd_vld", 64'(bus.exp_mem_rd_vld), 64'd0);
    tick();
    @(negedge clk);
    check("z_done_clear", 64'(done), 64'd0);
    check("z_fetches", 64'(nfetch - f0), 64'd0);
    tick();

    // Credit limit: no results returned until released one at a time
    auto_ret = 1'b0;
    f0 = nfetch;
    pulse_start(8'd2);
    pulse_start(8'd1);
    repeat (60) tick();
    @(negedge clk);
    check("c_fetches_cap", 64'(nfetch - f0), 64'd35);
    check("c_rd_vld_off", 64'(bus.exp_mem_rd_vld), 64'd0);
    check("c_busy", 64'(busy), 64'd1);
    tick();
    man_pulse = 1'b1;
    tick();
    man_pulse = 1'b0;
    repeat (10) tick();
    check("c_fetches_one_more", 64'(nfetch - f0), 64'd36);
    auto_ret = 1'b1;
    wait_done("c_done", 600);
    check("c_fetches_total", 64'(nfetch - f0), 64'd72);

    // Random backpressure
    f0 = nfetch; s0 = nfst;
    pulse_start(8'd2);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      bus.expected_rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("r_done", 64'(done), 64'd1);
    bus.expected_rdy = 1'b1;
    tick();
    check("r_fetches", 64'(nfetch - f0), 64'd72);
    check("r_fst_count", 64'(nfst - s0), 64'd2);

    // Reset in the middle of a run
    f0 = nfetch; d0 = ndone;
    pulse_start(8'd3);
    n = 0;
    while ((nfetch - f0) < 10 && n < 100) begin
      tick();
      n++;
    end
    check("m_reached_10", 64'((nfetch - f0) >= 10), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("m_vld", 64'(bus.expected_vld), 64'd0);
    check("m_busy", 64'(busy), 64'd0);
    check("m_rd_vld", 64'(bus.exp_mem_rd_vld), 64'd0);
    check("m_addr", 64'(bus.exp_mem_rd_address), 64'd0);
    repeat (5) tick();
    check("m_no_done", 64'(ndone - d0), 64'd0);
    f0 = nfetch;
    pulse_start(8'd1);
    @(negedge clk);
    check("m_restart_rd", 64'(bus.exp_mem_rd_vld), 64'd1);
    check("m_restart_addr", 64'(bus.exp_mem_rd_address), 64'd0);
    wait_done("m_done", 400);
    check("m_fetches", 64'(nfetch - f0), 64'd36);

    // Five frames from address 36: wraps 143 -> 0 once
    f0 = nfetch; s0 = nfst; w0 = nwrap; d0 = ndone;
    pulse_start(8'd5);
    wait_done("w_done", 1500);
    repeat (2) tick();
    check("w_fetches", 64'(nfetch - f0), 64'd180);
    check("w_fst_count", 64'(nfst - s0), 64'd5);
    check("w_wraps", 64'(nwrap - w0), 64'd1);
    check("w_done_count", 64'(ndone - d0), 64'd1);
    check("w_end_addr", 64'(bus.exp_mem_rd_address), 64'd72);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
